// File: rtl/contador_bcd_varredura.sv
// contador_bcd_varredura
// Four-digit BCD up/down counter with a time-multiplexed display scanner
// feeding a BCD-to-seven-segment decoder.
//
// Parameters:
//   DIV_VARREDURA  clock cycles per scan slot (>= 2)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   habilita     count enable, qualifies pulso
//   pulso        one-cycle count request
//   direcao      1 = up, 0 = down
//   carrega      synchronous load request (wins over pulso)
//   valor_carga  BCD load value, [15:12] thousands .. [3:0] units
//   apaga_zeros  1 = blank leading zeros on the display
//   contagem     current BCD count
//   estouro      one-cycle pulse on 9999<->0000 wrap
//   erro_carga   one-cycle pulse when a load nibble was > 9
//   digito       BCD digit for the decoder, 4'b1111 = blank
//   anodo        active-low one-hot digit enables, bit 0 = units
module contador_bcd_varredura #(
    parameter int unsigned DIV_VARREDURA = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        habilita,
    input  logic        pulso,
    input  logic        direcao,
    input  logic        carrega,
    input  logic [15:0] valor_carga,
    input  logic        apaga_zeros,
    output logic [15:0] contagem,
    output logic        estouro,
    output logic        erro_carga,
    output logic [3:0]  digito,
    output logic [3:0]  anodo
);

    localparam int unsigned DIV_W = $clog2(DIV_VARREDURA);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_VARREDURA - 1);

    logic [DIV_W-1:0] divisor;
    logic [1:0]       indice;

    logic [15:0] carga_limpa;
    logic [3:0]  nibble_invalido;
    logic [15:0] conta_mais;
    logic [15:0] conta_menos;
    logic        vai_um;
    logic        empresta;
    logic [3:0]  digito_sel;
    logic [3:0]  apagado;
    logic [3:0]  prox_digito;
    logic [3:0]  prox_anodo;

    // Load sanitising: any non-BCD nibble becomes 0 and is flagged.
    always_comb begin
        carga_limpa     = '0;
        nibble_invalido = '0;
        for (int i = 0; i < 4; i++) begin
            if (valor_carga[4*i +: 4] > 4'd9) begin
                nibble_invalido[i] = 1'b1;
            end else begin
                carga_limpa[4*i +: 4] = valor_carga[4*i +: 4];
            end
        end
    end

    // BCD increment: ripple the carry while digits roll over 9 -> 0.
    always_comb begin
        conta_mais = contagem;
        vai_um     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (vai_um) begin
                if (contagem[4*i +: 4] == 4'd9) begin
                    conta_mais[4*i +: 4] = 4'd0;
                end else begin
                    conta_mais[4*i +: 4] = contagem[4*i +: 4] + 4'd1;
                    vai_um               = 1'b0;
                end
            end
        end
    end

    // BCD decrement: ripple the borrow while digits roll under 0 -> 9.
    always_comb begin
        conta_menos = contagem;
        empresta    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (empresta) begin
                if (contagem[4*i +: 4] == 4'd0) begin
                    conta_menos[4*i +: 4] = 4'd9;
                end else begin
                    conta_menos[4*i +: 4] = contagem[4*i +: 4] - 4'd1;
                    empresta              = 1'b0;
                end
            end
        end
    end

    // Counter state with reset > load > qualified pulse > hold priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            contagem   <= '0;
            estouro    <= 1'b0;
            erro_carga <= 1'b0;
        end else if (carrega) begin
            contagem   <= carga_limpa;
            estouro    <= 1'b0;
            erro_carga <= |nibble_invalido;
        end else if (habilita && pulso) begin
            erro_carga <= 1'b0;
            if (direcao) begin
                contagem <= conta_mais;
                estouro  <= (contagem == 16'h9999);
            end else begin
                contagem <= conta_menos;
                estouro  <= (contagem == 16'h0000);
            end
        end else begin
            estouro    <= 1'b0;
            erro_carga <= 1'b0;
        end
    end

    // Scan divider and slot index; free-running, only reset affects them.
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor <= '0;
            indice  <= 2'd0;
        end else if (divisor == DIV_MAX) begin
            divisor <= '0;
            indice  <= indice + 2'd1;
        end else begin
            divisor <= divisor + DIV_W'(1);
        end
    end

    // Leading-zero blanking cascades from thousands downward; units never blank.
    always_comb begin
        apagado    = 4'b0000;
        apagado[3] = apaga_zeros && (contagem[15:12] == 4'd0);
        apagado[2] = apagado[3] && (contagem[11:8] == 4'd0);
        apagado[1] = apagado[2] && (contagem[7:4] == 4'd0);
    end

    // Display selection for the current slot.
    always_comb begin
        digito_sel = 4'd0;
        case (indice)
            2'd0:    digito_sel = contagem[3:0];
            2'd1:    digito_sel = contagem[7:4];
            2'd2:    digito_sel = contagem[11:8];
            default: digito_sel = contagem[15:12];
        endcase
        prox_digito = apagado[indice] ? 4'b1111 : digito_sel;
        prox_anodo  = ~(4'b0001 << indice);
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            digito <= 4'b1111;
            anodo  <= 4'b1111;
        end else begin
            digito <= prox_digito;
            anodo  <= prox_anodo;
        end
    end

endmodule
